// File: rtl/axi_write_adapter.sv
// Single-outstanding AXI3 write master for the data-store path: latches one store,
// issues AW and W independently, waits for B and pulses write_done/write_error.
module axi_write_adapter #(
    parameter logic [3:0] AXI_ID   = 4'd0,
    parameter bit         KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [1:0]  size,
    input  logic        address_valid,
    output logic        address_ready,
    output logic        write_done,
    output logic        write_error
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, data_reg;
    logic [3:0]  strb_reg;
    logic [1:0]  size_reg;
    logic        awvalid_reg, wvalid_reg, bready_reg;
    logic        aw_done_reg, w_done_reg;
    logic        accept, aw_fire, w_fire, send_complete, b_fire;
    logic [31:0] mapped_addr;
    logic        unused_bid;

    assign unused_bid = ^bid;

    // kseg0 (100) and kseg1 (101) both fold onto the low 512 MB physical window.
    always_comb begin
        mapped_addr = address;
        if (KSEG_MAP && address[31:30] == 2'b10)
            mapped_addr = {3'b000, address[28:0]};
    end

    // Gated by reset so no request is reported as taken while reset is held.
    assign address_ready = reset && (state_reg == IDLE) && address_valid;
    assign accept        = address_ready;
    assign aw_fire       = awvalid_reg && awready;
    assign w_fire        = wvalid_reg && wready;
    assign send_complete = (state_reg == SEND) && (aw_done_reg || aw_fire) && (w_done_reg || w_fire);
    assign b_fire        = (state_reg == WAIT_B) && bvalid && bready_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)        state_next = SEND;
            SEND:    if (send_complete) state_next = WAIT_B;
            WAIT_B:  if (b_fire)        state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg    <= '0;
            data_reg    <= '0;
            strb_reg    <= '0;
            size_reg    <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg    <= mapped_addr;
                data_reg    <= wr_data;
                strb_reg    <= wr_strb;
                size_reg    <= size;
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (state_reg == SEND) begin
                if (aw_fire) begin
                    awvalid_reg <= 1'b0;
                    aw_done_reg <= 1'b1;
                end
                if (w_fire) begin
                    wvalid_reg <= 1'b0;
                    w_done_reg <= 1'b1;
                end
                if (send_complete)
                    bready_reg <= 1'b1;
            end
            if (b_fire)
                bready_reg <= 1'b0;
        end
    end

    assign awid        = AXI_ID;
    assign awaddr      = addr_reg;
    assign awlen       = 4'b0000;
    assign awsize      = {1'b0, size_reg};
    assign awburst     = 2'b00;
    assign awlock      = 2'b00;
    assign awcache     = 4'b0000;
    assign awprot      = 3'b001;
    assign awvalid     = awvalid_reg;
    assign wid         = AXI_ID;
    assign wdata       = data_reg;
    assign wstrb       = strb_reg;
    assign wlast       = 1'b1;
    assign wvalid      = wvalid_reg;
    assign bready      = bready_reg;
    assign write_done  = b_fire;
    assign write_error = b_fire && (bresp != 2'b00);

endmodule
